// File: rtl/psram_line_reader.sv
// psram_line_reader
//   Read-only burst initiator for one client port of the PSRAM arbiter.
//   A start pulse launches a run of num_bursts consecutive read bursts
//   beginning at base_addr; each returned word lands in an internal FIFO
//   drained by a display/DMA consumer. Single clock domain (psramclk).
//
// Ports
//   psramclk, rst_psclk          : clock, synchronous active-high reset
//   start, base_addr, num_bursts : run request and its parameters
//   busy, done                   : run in progress / end-of-run pulse
//   cmd, cmd_en, addr, wdata,
//   mask, cmd_ready              : arbiter command handshake (read only)
//   rdata, rvalid                : returned burst data from the arbiter
//   fifo_rd_en, fifo_rdata,
//   fifo_rvalid, fifo_empty,
//   fifo_level                   : consumer side of the FIFO
//   overflow                     : sticky, a returned word hit a full FIFO
module psram_line_reader #(
  parameter int BURST_WORDS = 16,
  parameter int ADDR_STEP   = 32,
  parameter int FIFO_AW     = 6
) (
  input  logic               psramclk,
  input  logic               rst_psclk,
  input  logic               start,
  input  logic [22:0]        base_addr,
  input  logic [7:0]         num_bursts,
  output logic               busy,
  output logic               done,
  output logic               cmd,
  output logic               cmd_en,
  output logic [22:0]        addr,
  output logic [31:0]        wdata,
  output logic [3:0]         mask,
  input  logic               cmd_ready,
  input  logic [31:0]        rdata,
  input  logic               rvalid,
  input  logic               fifo_rd_en,
  output logic [31:0]        fifo_rdata,
  output logic               fifo_rvalid,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BURST_WORDS + 1);

  typedef enum logic [2:0] {IDLE, SPACE, REQ, DATA, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_cmd_en, w_cmd_en_nxt;
  logic [22:0]        r_addr, w_addr_nxt;
  logic [7:0]         r_rem, w_rem_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;

  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW:0]   r_wr_ptr, r_rd_ptr;
  logic [31:0]        r_fifo_rdata;
  logic               r_fifo_rvalid;
  logic               r_overflow;

  logic [FIFO_AW:0]   w_level;
  logic               w_full, w_empty, w_push, w_pop, w_space_ok;

  // Extra pointer bit distinguishes full from empty.
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_level == (FIFO_AW+1)'(DEPTH));
  assign w_empty    = (w_level == '0);
  assign w_push     = rvalid & ~w_full;
  assign w_pop      = fifo_rd_en & ~w_empty;
  // Only request a burst once the whole burst is guaranteed to fit.
  assign w_space_ok = (w_level <= (FIFO_AW+1)'(DEPTH - BURST_WORDS));

  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_cmd_en_nxt = r_cmd_en;
    w_addr_nxt   = r_addr;
    w_rem_nxt    = r_rem;
    w_cnt_nxt    = rvalid ? r_cnt + CW'(1) : r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_addr_nxt  = base_addr;
          w_rem_nxt   = num_bursts;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = (num_bursts == 8'd0) ? DONE : SPACE;
        end
      end
      SPACE: begin
        if (w_space_ok) begin
          w_cmd_en_nxt = 1'b1;
          w_state_nxt  = REQ;
        end
      end
      REQ: begin
        if (cmd_ready) begin
          w_cmd_en_nxt = 1'b0;
          w_addr_nxt   = r_addr + 23'(ADDR_STEP);
          w_rem_nxt    = r_rem - 8'd1;
          w_state_nxt  = DATA;
        end
      end
      DATA: begin
        // One outstanding burst only: the arbiter steers rvalid by its last grant.
        if (rvalid && (r_cnt == CW'(BURST_WORDS - 1))) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_rem == 8'd0) ? DONE : SPACE;
        end
      end
      DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge psramclk) begin
    if (rst_psclk) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cmd_en <= 1'b0;
      r_addr   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_cmd_en <= w_cmd_en_nxt;
      r_addr   <= w_addr_nxt;
      r_rem    <= w_rem_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // FIFO control
  always_ff @(posedge psramclk) begin
    if (rst_psclk) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fifo_rvalid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fifo_rvalid <= w_pop;
      if (rvalid && w_full) r_overflow <= 1'b1;
    end
  end

  // FIFO storage and read data (no reset on the data path)
  always_ff @(posedge psramclk) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= rdata;
    if (w_pop)  r_fifo_rdata <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign cmd         = 1'b0;
  assign cmd_en      = r_cmd_en;
  assign addr        = r_addr;
  assign wdata       = 32'd0;
  assign mask        = 4'd0;
  assign fifo_rdata  = r_fifo_rdata;
  assign fifo_rvalid = r_fifo_rvalid;
  assign fifo_empty  = w_empty;
  assign fifo_level  = w_level;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_psram_line_reader.sv
module tb_psram_line_reader;

  logic        psramclk = 1'b0;
  logic        rst_psclk = 1'b1;
  logic        start = 1'b0;
  logic [22:0] base_addr = '0;
  logic [7:0]  num_bursts = '0;
  logic        busy, done, cmd, cmd_en;
  logic [22:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        cmd_ready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        fifo_rd_en = 1'b0;
  logic [31:0] fifo_rdata;
  logic        fifo_rvalid, fifo_empty;
  logic [6:0]  fifo_level;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int          grant_cnt = 0;
  int          done_cnt  = 0;
  logic [22:0] g_addr [0:255];

  psram_line_reader #(.BURST_WORDS(16), .ADDR_STEP(32), .FIFO_AW(6)) dut (
    .psramclk(psramclk), .rst_psclk(rst_psclk), .start(start),
    .base_addr(base_addr), .num_bursts(num_bursts), .busy(busy), .done(done),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wdata(wdata), .mask(mask),
    .cmd_ready(cmd_ready), .rdata(rdata), .rvalid(rvalid),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 psramclk = ~psramclk;

  // Record grants and done pulses mid-cycle.
  always @(negedge psramclk) begin
    if (cmd_en && cmd_ready) begin
      if (grant_cnt < 256) g_addr[grant_cnt] <= addr;
      grant_cnt <= grant_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge psramclk);
    #1;
  endtask

  task automatic do_start(input logic [22:0] b, input logic [7:0] n);
    base_addr = b; num_bursts = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] first, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) repeat ($urandom_range(0, 3)) tick();
      rvalid = 1'b1; rdata = first + 32'(i);
      tick();
      rvalid = 1'b0;
    end
  endtask

  task automatic grant_after(input int dly, output bit ok);
    int w;
    w = 0;
    while (!cmd_en && w < 50) begin tick(); w++; end
    if (!cmd_en) ok = 1'b0;
    else begin
      repeat (dly) tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic drain(input int n);
    fifo_rd_en = 1'b1;
    repeat (n) tick();
    fifo_rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_psclk = 1'b1;
    tick(); tick();
    rst_psclk = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en: got %b want 0", cmd_en); end
    n_checks++; if (fifo_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rvalid: got %b want 0", fifo_rvalid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (addr !== 23'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_checks++; if ({cmd, wdata, mask} !== 37'd0) begin n_fail++; $display("FAIL const_outputs: got %h want 0", {cmd, wdata, mask}); end
  endtask

  task automatic test_single_burst();
    int g0, d0;
    bit seen;
    g0 = grant_cnt; d0 = done_cnt;
    do_start(23'h000100, 8'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T1: got %b want 1", busy); end
    n_checks++; if (cmd_en !== 1'b0) begin n_fail++; $display("FAIL single_cmd_en_T1: got %b want 0", cmd_en); end
    tick();
    n_checks++; if (cmd_en !== 1'b1) begin n_fail++; $display("FAIL single_cmd_en_T2: got %b want 1", cmd_en); end
    n_checks++; if (addr !== 23'h000100) begin n_fail++; $display("FAIL single_addr: got %h want 000100", addr); end
    n_checks++; if (cmd !== 1'b0) begin n_fail++; $display("FAIL single_cmd: got %b want 0", cmd); end
    repeat (2) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    n_checks++; if (cmd_en !== 1'b0) begin n_fail++; $display("FAIL single_cmd_en_drop: got %b want 0", cmd_en); end
    n_checks++; if (addr !== 23'h000120) begin n_fail++; $display("FAIL single_addr_inc: got %h want 000120", addr); end
    send_words(16, 32'd0, 1'b0);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_early: got %b want 0", done); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    n_checks++; if (fifo_level !== 7'd16) begin n_fail++; $display("FAIL single_level: got %0d want 16", fifo_level); end
    wait_done(seen);
    n_checks++; if (grant_cnt - g0 !== 1) begin n_fail++; $display("FAIL single_grants: got %0d want 1", grant_cnt - g0); end
    n_checks++; if (g_addr[g0] !== 23'h000100) begin n_fail++; $display("FAIL single_grant_addr: got %h want 000100", g_addr[g0]); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); end
    fifo_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) fifo_rd_en = 1'b0;
      n_checks++;
      if (fifo_rvalid !== 1'b1 || fifo_rdata !== 32'(i)) begin
        n_fail++; $display("FAIL single_pop%0d: got v=%b d=%h want v=1 d=%h", i, fifo_rvalid, fifo_rdata, 32'(i));
      end
    end
    tick();
    n_checks++; if (fifo_rvalid !== 1'b0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_after_pop: got v=%b e=%b want v=0 e=1", fifo_rvalid, fifo_empty); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    n_checks++; if (fifo_rvalid !== 1'b0 || fifo_level !== 7'd0) begin n_fail++; $display("FAIL empty_pop_ignored: got v=%b lvl=%0d want v=0 lvl=0", fifo_rvalid, fifo_level); end
  endtask

  task automatic test_gapped();
    int g0;
    bit ok, seen;
    g0 = grant_cnt;
    do_start(23'h000100, 8'd3);
    for (int b = 0; b < 3; b++) begin
      grant_after(2, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL gapped_req_timeout%0d: got no cmd_en want cmd_en", b); end
      send_words(16, 32'h1000 + 32'(16 * b), 1'b1);
    end
    wait_done(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL gapped_done: got none want pulse"); end
    n_checks++; if (fifo_level !== 7'd48) begin n_fail++; $display("FAIL gapped_level: got %0d want 48", fifo_level); end
    n_checks++; if (g_addr[g0] !== 23'h100) begin n_fail++; $display("FAIL gapped_addr0: got %h want 100", g_addr[g0]); end
    n_checks++; if (g_addr[g0+1] !== 23'h120) begin n_fail++; $display("FAIL gapped_addr1: got %h want 120", g_addr[g0+1]); end
    n_checks++; if (g_addr[g0+2] !== 23'h140) begin n_fail++; $display("FAIL gapped_addr2: got %h want 140", g_addr[g0+2]); end
    repeat (20) tick();
    n_checks++; if (grant_cnt - g0 !== 3 || cmd_en !== 1'b0) begin n_fail++; $display("FAIL gapped_no_4th: got grants=%0d cmd_en=%b want 3/0", grant_cnt - g0, cmd_en); end
    fifo_rd_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (i == 47) fifo_rd_en = 1'b0;
      n_checks++;
      if (fifo_rdata !== 32'h1000 + 32'(i)) begin n_fail++; $display("FAIL gapped_pop%0d: got %h want %h", i, fifo_rdata, 32'h1000 + 32'(i)); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int g0;
    bit ok, seen;
    g0 = grant_cnt;
    do_start(23'h000200, 8'd5);
    for (int b = 0; b < 4; b++) begin
      grant_after(1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_req_timeout%0d: got no cmd_en want cmd_en", b); end
      send_words(16, 32'h2000 + 32'(16 * b), 1'b0);
    end
    repeat (10) tick();
    n_checks++; if (fifo_level !== 7'd64) begin n_fail++; $display("FAIL bp_level_full: got %0d want 64", fifo_level); end
    n_checks++; if (cmd_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_wait_space: got cmd_en=%b busy=%b want 0/1", cmd_en, busy); end
    n_checks++; if (grant_cnt - g0 !== 4) begin n_fail++; $display("FAIL bp_grants4: got %0d want 4", grant_cnt - g0); end
    fifo_rd_en = 1'b1;
    repeat (16) tick();
    fifo_rd_en = 1'b0;
    grant_after(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_5th_req: got no cmd_en want cmd_en"); end
    n_checks++; if (g_addr[g0+4] !== 23'h280) begin n_fail++; $display("FAIL bp_addr5: got %h want 280", g_addr[g0+4]); end
    send_words(16, 32'h2040, 1'b0);
    wait_done(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_done: got none want pulse"); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow: got %b want 0", overflow); end
    n_checks++; if (fifo_level !== 7'd64) begin n_fail++; $display("FAIL bp_level_end: got %0d want 64", fifo_level); end
    drain(64);
  endtask

  task automatic test_zero_bursts();
    int g0;
    g0 = grant_cnt;
    do_start(23'h000333, 8'd0);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_T1: got busy=%b done=%b want 1/0", busy, done); end
    tick();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_T2: got done=%b busy=%b want 1/0", done, busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_len: got %b want 0", done); end
    repeat (5) tick();
    n_checks++; if (grant_cnt !== g0 || cmd_en !== 1'b0) begin n_fail++; $display("FAIL zero_no_cmd: got grants=%0d cmd_en=%b want %0d/0", grant_cnt, cmd_en, g0); end
  endtask

  task automatic test_wrap();
    int g0;
    bit ok, seen;
    g0 = grant_cnt;
    do_start(23'h7FFFE0, 8'd2);
    for (int b = 0; b < 2; b++) begin
      grant_after(0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_req_timeout%0d: got no cmd_en want cmd_en", b); end
      send_words(16, 32'h3000, 1'b0);
    end
    wait_done(seen);
    n_checks++; if (g_addr[g0] !== 23'h7FFFE0) begin n_fail++; $display("FAIL wrap_addr0: got %h want 7fffe0", g_addr[g0]); end
    n_checks++; if (g_addr[g0+1] !== 23'h000000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 000000", g_addr[g0+1]); end
    n_checks++; if (addr !== 23'h000020) begin n_fail++; $display("FAIL wrap_addr_end: got %h want 000020", addr); end
    drain(32);
  endtask

  task automatic test_start_ignored();
    int g0;
    bit ok, seen;
    g0 = grant_cnt;
    do_start(23'h000300, 8'd2);
    tick();
    do_start(23'h000555, 8'd7);
    n_checks++; if (addr !== 23'h000300) begin n_fail++; $display("FAIL busy_start_addr: got %h want 000300", addr); end
    grant_after(0, ok);
    send_words(3, 32'h4000, 1'b0);
    do_start(23'h000555, 8'd7);
    send_words(13, 32'h4003, 1'b0);
    grant_after(0, ok);
    n_checks++; if (!ok || g_addr[g0+1] !== 23'h000320) begin n_fail++; $display("FAIL busy_start_addr2: got %h want 000320", g_addr[g0+1]); end
    send_words(16, 32'h4010, 1'b0);
    wait_done(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL busy_start_done: got none want pulse"); end
    repeat (10) tick();
    n_checks++; if (grant_cnt - g0 !== 2) begin n_fail++; $display("FAIL busy_start_grants: got %0d want 2", grant_cnt - g0); end
    drain(32);
  endtask

  task automatic test_stall();
    bit seen;
    int w;
    do_start(23'h000400, 8'd1);
    w = 0;
    while (!cmd_en && w < 20) begin tick(); w++; end
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if (cmd_en !== 1'b1 || addr !== 23'h000400) begin n_fail++; $display("FAIL stall_hold%0d: got cmd_en=%b addr=%h want 1/000400", i, cmd_en, addr); end
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    n_checks++; if (cmd_en !== 1'b0 || addr !== 23'h000420) begin n_fail++; $display("FAIL stall_release: got cmd_en=%b addr=%h want 0/000420", cmd_en, addr); end
    send_words(16, 32'h5000, 1'b1);
    wait_done(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_done: got none want pulse"); end
    drain(16);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(23'h000500, 8'd2);
    grant_after(0, ok);
    send_words(5, 32'h6000, 1'b0);
    rst_psclk = 1'b1;
    tick();
    rst_psclk = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got busy=%b done=%b cmd_en=%b want 0/0/0", busy, done, cmd_en); end
    n_checks++; if (addr !== 23'h0 || fifo_level !== 7'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_fifo: got addr=%h lvl=%0d empty=%b want 0/0/1", addr, fifo_level, fifo_empty); end
    n_checks++; if (fifo_rvalid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got rv=%b ovf=%b want 0/0", fifo_rvalid, overflow); end
    repeat (5) tick();
    n_checks++; if (cmd_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got cmd_en=%b busy=%b want 0/0", cmd_en, busy); end
    send_words(1, 32'hABCD0001, 1'b0);
    n_checks++; if (fifo_level !== 7'd1) begin n_fail++; $display("FAIL rstmid_late_rvalid: got %0d want 1", fifo_level); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    n_checks++; if (fifo_rdata !== 32'hABCD0001) begin n_fail++; $display("FAIL rstmid_late_data: got %h want abcd0001", fifo_rdata); end
    tick();
  endtask

  task automatic test_overflow();
    send_words(64, 32'h7000, 1'b0);
    n_checks++; if (fifo_level !== 7'd64 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got lvl=%0d ovf=%b want 64/0", fifo_level, overflow); end
    send_words(1, 32'hDEAD, 1'b0);
    n_checks++; if (overflow !== 1'b1 || fifo_level !== 7'd64) begin n_fail++; $display("FAIL ovf_set: got ovf=%b lvl=%0d want 1/64", overflow, fifo_level); end
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    n_checks++; if (fifo_rdata !== 32'h7000) begin n_fail++; $display("FAIL ovf_first_word: got %h want 7000", fifo_rdata); end
    repeat (9) tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    rst_psclk = 1'b1;
    tick();
    rst_psclk = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_gapped();
    test_backpressure();
    test_zero_bursts();
    test_wrap();
    test_start_ignored();
    test_stall();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
